alu_cmd_ctrl: RTL and testbench

Command front-end for the ALU. It parses a byte stream from the UART receive path into ALU operand and function frames, and drives the ALU operand, function and enable inputs. It captures the 16-bit registered ALU result on its valid strobe and serialises it, low byte first, to the UART transmit path over a valid/busy handshake. It sits directly upstream of the ALU and downstream of the receive-side data synchroniser.

---
 rtl/alu_cmd_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_alu_cmd_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_ctrl.sv
// Command front-end for the ALU: parses CC/DD byte frames into operands and a function,
// pulses ALU_EN, then returns the 16-bit ALU result to the transmitter low byte first.
module alu_cmd_ctrl #(
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           OUT_WIDTH  = 2 * DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] CMD_OPS    = DATA_WIDTH'(8'hCC),
    parameter logic [DATA_WIDTH-1:0] CMD_FUN    = DATA_WIDTH'(8'hDD),
    parameter int unsigned           TIMEOUT    = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] ALU_A,
    output logic [DATA_WIDTH-1:0] ALU_B,
    output logic [3:0]            ALU_FUN,
    output logic                  ALU_EN,
    input  logic [OUT_WIDTH-1:0]  alu_out,
    input  logic                  alu_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_busy,
    output logic                  busy,
    output logic                  err,
    output logic [1:0]            err_code
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ERR_CMD     = 2'b01;
    localparam logic [1:0] ERR_OVERRUN = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_A,
        S_GET_B,
        S_GET_FUN,
        S_RUN,
        S_WAIT_RES,
        S_SEND_LO,
        S_SEND_HI
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [DATA_WIDTH-1:0]   alu_b_q, alu_b_d;
    logic [3:0]              alu_fun_q, alu_fun_d;
    logic                    alu_en_q, alu_en_d;
    logic [OUT_WIDTH-1:0]    res_q, res_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                    tx_valid_q, tx_valid_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;
    logic [1:0]              err_code_q, err_code_d;

    // Next-state and registered-output logic; outputs are computed for the state being entered.
    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_fun_d  = alu_fun_q;
        alu_en_d   = 1'b0;
        res_d      = res_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        err_d      = 1'b0;
        err_code_d = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_OPS) begin
                        state_d = S_GET_A;
                    end else if (rx_data == CMD_FUN) begin
                        state_d = S_GET_FUN;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_CMD;
                    end
                end
            end
            S_GET_A: begin
                if (rx_valid) begin
                    alu_a_d = rx_data;
                    state_d = S_GET_B;
                end
            end
            S_GET_B: begin
                if (rx_valid) begin
                    alu_b_d = rx_data;
                    state_d = S_GET_FUN;
                end
            end
            S_GET_FUN: begin
                if (rx_valid) begin
                    alu_fun_d = rx_data[3:0];
                    alu_en_d  = 1'b1;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                // Counter tracks cycles since ALU_EN, so the timeout error lands TIMEOUT cycles after it.
                cnt_d   = CNT_W'(1);
                state_d = S_WAIT_RES;
            end
            S_WAIT_RES: begin
                if (alu_valid) begin
                    res_d      = alu_out;
                    tx_data_d  = alu_out[DATA_WIDTH-1:0];
                    tx_valid_d = 1'b1;
                    state_d    = S_SEND_LO;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SEND_LO: begin
                if (!tx_busy) begin
                    tx_data_d = res_q[OUT_WIDTH-1 -: DATA_WIDTH];
                    state_d   = S_SEND_HI;
                end
            end
            S_SEND_HI: begin
                if (!tx_busy) begin
                    tx_data_d  = '0;
                    tx_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Bytes arriving while a command is executing are dropped and flagged.
        if (rx_valid && !err_d &&
            (state_q inside {S_RUN, S_WAIT_RES, S_SEND_LO, S_SEND_HI})) begin
            err_d      = 1'b1;
            err_code_d = ERR_OVERRUN;
        end
    end

    always_comb begin
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_fun_q  <= '0;
            alu_en_q   <= 1'b0;
            res_q      <= '0;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_fun_q  <= alu_fun_d;
            alu_en_q   <= alu_en_d;
            res_q      <= res_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign ALU_A    = alu_a_q;
    assign ALU_B    = alu_b_q;
    assign ALU_FUN  = alu_fun_q;
    assign ALU_EN   = alu_en_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign err      = err_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Self-checking bench for alu_cmd_ctrl: directed frames followed by randomized frames,
// checked cycle by cycle against a frame-level model of expected ALU and transmit activity.
module tb_alu_cmd_ctrl;

    localparam int unsigned TIMEOUT = 4;
    localparam logic [7:0]  CMD_OPS = 8'hCC;
    localparam logic [7:0]  CMD_FUN = 8'hDD;

    logic        CLK;
    logic        RST;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  ALU_A;
    logic [7:0]  ALU_B;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN;
    logic [15:0] alu_out;
    logic        alu_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_busy;
    logic        busy;
    logic        err;
    logic [1:0]  err_code;

    int n_cmp;
    int n_err;

    // Model of the operand/function registers as seen by the ALU.
    logic [7:0] m_a;
    logic [7:0] m_b;
    logic [3:0] m_fun;

    alu_cmd_ctrl #(
        .DATA_WIDTH(8),
        .OUT_WIDTH (16),
        .CMD_OPS   (CMD_OPS),
        .CMD_FUN   (CMD_FUN),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .ALU_A    (ALU_A),
        .ALU_B    (ALU_B),
        .ALU_FUN  (ALU_FUN),
        .ALU_EN   (ALU_EN),
        .alu_out  (alu_out),
        .alu_valid(alu_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_busy  (tx_busy),
        .busy     (busy),
        .err      (err),
        .err_code (err_code)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".alu"}, 32'({ALU_A, ALU_B, ALU_FUN, ALU_EN}), 32'd0);
        chk({tag, ".tx"},  32'({tx_data, tx_valid}), 32'd0);
        chk({tag, ".st"},  32'({busy, err, err_code}), 32'd0);
    endtask

    // One rx byte, optionally preceded by idle cycles.
    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int i = 0; i < gap; i++) tick();
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic unknown_cmd(input logic [7:0] b);
        send_byte(b, 0);
        chk("unk.err",  32'(err), 32'd1);
        chk("unk.code", 32'(err_code), 32'd1);
        chk("unk.en",   32'(ALU_EN), 32'd0);
        chk("unk.busy", 32'(busy), 32'd0);
        tick();
        chk("unk.err_clr", 32'(err), 32'd0);
    endtask

    // Full command frame. lat: cycles after ALU_EN at which the bench ALU answers
    // (>= TIMEOUT means it never answers). busy_n: cycles tx_busy is held at first tx_valid.
    task automatic frame(input bit ops, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] fun, input logic [15:0] res, input int lat,
                         input int busy_n, input bit extra_rx, input bit rst_hi);
        logic [7:0] exp_bytes [2];
        bit         tout;
        bit         done;
        bit         exp_err;
        bit         exp_txv;
        int         xfers;
        int         k;

        tout = (lat >= int'(TIMEOUT));
        exp_bytes[0] = res[7:0];
        exp_bytes[1] = res[15:8];

        if (ops) begin
            send_byte(CMD_OPS, int'($urandom_range(0, 1)));
            chk("hdr.busy", 32'(busy), 32'd1);
            send_byte(a, int'($urandom_range(0, 1)));
            chk("a.busy", 32'(busy), 32'd1);
            send_byte(b, int'($urandom_range(0, 1)));
            chk("b.en", 32'(ALU_EN), 32'd0);
            m_a = a;
            m_b = b;
        end else begin
            send_byte(CMD_FUN, int'($urandom_range(0, 1)));
            chk("hdr.busy", 32'(busy), 32'd1);
        end
        send_byte(fun, int'($urandom_range(0, 1)));
        m_fun = fun[3:0];

        k     = 0;
        xfers = 0;
        done  = 1'b0;
        while (!done && k < 64) begin
            alu_valid = !tout && (k == lat);
            alu_out   = alu_valid ? res : 16'($urandom);
            rx_valid  = extra_rx && (k == 1);
            rx_data   = 8'($urandom);
            tx_busy   = !tout && (k >= lat + 1) && (k <= lat + busy_n);

            if (rst_hi && xfers == 1) begin
                #2 RST = 1'b1;
                #1;
                chk_all_zero("rst_async");
                alu_valid = 1'b0;
                rx_valid  = 1'b0;
                tx_busy   = 1'b0;
                tick();
                chk_all_zero("rst_hold");
                RST = 1'b0;
                m_a   = '0;
                m_b   = '0;
                m_fun = '0;
                done  = 1'b1;
            end else begin
                chk("alu_en", 32'(ALU_EN), 32'(k == 0));
                if (k == 0) begin
                    chk("alu_a",   32'(ALU_A), 32'(m_a));
                    chk("alu_b",   32'(ALU_B), 32'(m_b));
                    chk("alu_fun", 32'(ALU_FUN), 32'(m_fun));
                end
                exp_err = (extra_rx && k == 2) || (tout && k == int'(TIMEOUT));
                chk("err", 32'(err), 32'(exp_err));
                if (exp_err) chk("err_code", 32'(err_code), (k == 2) ? 32'd2 : 32'd3);

                if (tout && k == int'(TIMEOUT)) begin
                    chk("tout.busy", 32'(busy), 32'd0);
                    chk("tout.txv",  32'(tx_valid), 32'd0);
                    done = 1'b1;
                end else begin
                    chk("busy", 32'(busy), 32'd1);
                    exp_txv = !tout && (k >= lat + 1);
                    chk("tx_valid", 32'(tx_valid), 32'(exp_txv));
                    if (exp_txv) begin
                        chk("tx_data", 32'(tx_data), 32'(exp_bytes[xfers]));
                        if (!tx_busy) xfers++;
                    end
                    if (xfers == 2) begin
                        tick();
                        tx_busy   = 1'b0;
                        alu_valid = 1'b0;
                        chk("end.busy", 32'(busy), 32'd0);
                        chk("end.txv",  32'(tx_valid), 32'd0);
                        chk("end.err",  32'(err), 32'd0);
                        done = 1'b1;
                    end
                end
            end
            if (!done) begin
                tick();
                k++;
            end
        end
        if (!done) chk("frame_budget", 32'd0, 32'd1);
        alu_valid = 1'b0;
        rx_valid  = 1'b0;
        tx_busy   = 1'b0;
        tick();
    endtask

    initial begin
        logic [7:0] ub;
        bit         r_ops;
        int         r_lat;

        n_cmp     = 0;
        n_err     = 0;
        m_a       = '0;
        m_b       = '0;
        m_fun     = '0;
        RST       = 1'b1;
        rx_data   = '0;
        rx_valid  = 1'b0;
        alu_out   = '0;
        alu_valid = 1'b0;
        tx_busy   = 1'b0;

        tick();
        tick();
        chk_all_zero("reset");
        RST = 1'b0;
        tick();
        chk_all_zero("post_reset");

        // Add frame, then operand reuse.
        frame(1'b1, 8'h12, 8'h34, 8'h00, 16'h0046, 1, 0, 1'b0, 1'b0);
        frame(1'b0, 8'h00, 8'h00, 8'h02, 16'h03A8, 1, 0, 1'b0, 1'b0);
        chk("reuse.a", 32'(ALU_A), 32'h12);
        chk("reuse.b", 32'(ALU_B), 32'h34);
        chk("reuse.fun", 32'(ALU_FUN), 32'h2);

        // Backpressure during the low byte.
        frame(1'b1, 8'h5A, 8'hA5, 8'h03, 16'hBEEF, 1, 7, 1'b0, 1'b0);

        unknown_cmd(8'h55);

        // Overrun during WAIT_RES, and the alu_valid/timeout tie.
        frame(1'b1, 8'h01, 8'h02, 8'h01, 16'h1234, 2, 0, 1'b1, 1'b0);
        frame(1'b0, 8'h00, 8'h00, 8'h04, 16'hCAFE, int'(TIMEOUT) - 1, 2, 1'b0, 1'b0);

        // Timeout, then a normal frame.
        frame(1'b1, 8'h77, 8'h88, 8'h05, 16'h0000, 99, 0, 1'b0, 1'b0);
        frame(1'b1, 8'h10, 8'h20, 8'h06, 16'h8001, 1, 0, 1'b0, 1'b0);

        // Reset in SEND_HI, then a clean frame.
        frame(1'b1, 8'h99, 8'h66, 8'h07, 16'hABCD, 1, 0, 1'b0, 1'b1);
        chk("rst.model_a", 32'(ALU_A), 32'(m_a));
        frame(1'b1, 8'h3C, 8'hC3, 8'hF8, 16'h5AA5, 1, 0, 1'b0, 1'b0);

        // Randomized frames.
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                do ub = 8'($urandom); while (ub == CMD_OPS || ub == CMD_FUN);
                unknown_cmd(ub);
            end
            r_ops = ($urandom_range(0, 2) != 0);
            r_lat = ($urandom_range(0, 9) == 0) ? 50 : int'($urandom_range(1, TIMEOUT - 1));
            frame(r_ops, 8'($urandom), 8'($urandom), 8'($urandom), 16'($urandom),
                  r_lat, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
